// File: rtl/up_frame_pkg.sv
// up_frame_pkg -- shared constants for the upstream frame transmitter:
// frame header bytes, FSM state encoding and the status-frame builder.
package up_frame_pkg;

   localparam logic [7:0] HDR_STATUS = 8'hB1;
   localparam logic [7:0] HDR_VDC    = 8'hB2;
   localparam logic [7:0] HDR_TEMP   = 8'hB3;
   localparam logic [7:0] HDR_FAULT  = 8'hBF;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEL       = 3'd1,
      LAUNCH    = 3'd2,
      WAIT_ACK  = 3'd3,
      WAIT_DONE = 3'd4,
      GAP       = 3'd5
   } tx_state_t;

   // Status and fault frames carry the status byte followed by its complement
   // so the receiver can reject a corrupted byte.
   function automatic logic [23:0] st_frame(input logic [7:0] hdr, input logic [7:0] st);
      return {hdr, st, ~st};
   endfunction

endpackage

// File: rtl/up_frame_tx_flt_edge.sv
// up_flt_edge -- rising-edge detector over {fault, igbt_flt[3:0]} that
// raises fault_pend until the transmitter selects the fault frame.
// The history register is loaded with the live inputs during reset, so a
// fault level already present at reset release never looks like an edge.
module up_flt_edge
   import up_frame_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       fault,
   input  logic [3:0] igbt_flt,
   input  logic       pend_clr,
   output logic       fault_pend
);

   logic [4:0] flt_now;
   logic [4:0] flt_hist_reg;
   logic [4:0] flt_rise;
   logic       fault_pend_reg;

   assign flt_now = {fault, igbt_flt};

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_rise
         assign flt_rise[gi] = flt_now[gi] & ~flt_hist_reg[gi];
      end
   endgenerate

   // Track input history and hold one pending fault request; a new edge wins
   // over a same-cycle clear so a fault arriving after the status byte was
   // sampled still gets reported.
   always_ff @(posedge clk) begin
      if (rst) begin
         flt_hist_reg   <= flt_now;
         fault_pend_reg <= 1'b0;
      end else begin
         flt_hist_reg <= flt_now;
         if (|flt_rise) begin
            fault_pend_reg <= 1'b1;
         end else if (pend_clr) begin
            fault_pend_reg <= 1'b0;
         end
      end
   end

   assign fault_pend = fault_pend_reg;

endmodule

// File: rtl/up_frame_tx.sv
// up_frame_tx -- periodic status/voltage(/temperature) report and
// event-driven fault frame transmitter with a busy-flag serializer handshake.
// Optional feature: define UP_TEMP_FRAME_EN to add the temperature frame to
// each report cycle; without it a report cycle is status + voltage only.
module up_frame_tx
   import up_frame_pkg::*;
#(
   parameter logic [12:0] TX_TIMEOUT = 13'd4000,
   parameter logic [7:0]  FRM_GAP    = 8'd16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sync_tick,
   input  logic        fault,
   input  logic [3:0]  igbt_flt,
   input  logic        Lockn,
   input  logic        start,
   input  logic        bypass,
   input  logic [15:0] vdc_data,
   input  logic [15:0] temp_data,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [23:0] tx_data,
   output logic        tx_err,
   output logic        sync_ovr
);

   tx_state_t   state_reg;
   logic [12:0] cnt_reg;
   logic        sts_pend_reg;
   logic        vdc_pend_reg;
   logic [15:0] vdc_snap_reg;
   logic        tx_start_reg;
   logic [23:0] tx_data_reg;
   logic        tx_err_reg;
   logic        sync_ovr_reg;

   logic        fault_pend;
   logic        flt_clr;
   logic [7:0]  st_byte;
   logic        wait_expired;
   logic        gap_done;

`ifdef UP_TEMP_FRAME_EN
   logic        tmp_pend_reg;
   logic [15:0] temp_snap_reg;
`else
   logic        unused_temp;
   assign unused_temp = ^temp_data;
`endif

   assign st_byte = {fault, igbt_flt, bypass, start, Lockn};

   // The fault frame always wins selection, so its request is consumed
   // whenever SEL sees it pending.
   assign flt_clr = (state_reg == SEL) && fault_pend;

   // cnt_reg restarts at 0 on entry to each wait/gap state, so these fire
   // after exactly TX_TIMEOUT / FRM_GAP cycles in that state.
   assign wait_expired = (cnt_reg + 13'd1) >= TX_TIMEOUT;
   assign gap_done     = (cnt_reg + 13'd1) >= {5'd0, FRM_GAP};

   up_flt_edge u_flt_edge (
      .clk        (clk),
      .rst        (rst),
      .fault      (fault),
      .igbt_flt   (igbt_flt),
      .pend_clr   (flt_clr),
      .fault_pend (fault_pend)
   );

   // Frame sequencer: selects, launches and supervises one frame at a time.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= 13'd0;
         sts_pend_reg  <= 1'b0;
         vdc_pend_reg  <= 1'b0;
         vdc_snap_reg  <= 16'h0;
`ifdef UP_TEMP_FRAME_EN
         tmp_pend_reg  <= 1'b0;
         temp_snap_reg <= 16'h0;
`endif
         tx_start_reg  <= 1'b0;
         tx_data_reg   <= 24'h0;
         tx_err_reg    <= 1'b0;
         sync_ovr_reg  <= 1'b0;
      end else begin
         tx_start_reg <= 1'b0;

         // Any report request outside IDLE is an overrun and is dropped.
         if (sync_tick && (state_reg != IDLE)) begin
            sync_ovr_reg <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (sync_tick) begin
                  vdc_snap_reg  <= vdc_data;
                  sts_pend_reg  <= 1'b1;
                  vdc_pend_reg  <= 1'b1;
`ifdef UP_TEMP_FRAME_EN
                  temp_snap_reg <= temp_data;
                  tmp_pend_reg  <= 1'b1;
`endif
                  state_reg     <= SEL;
               end else if (fault_pend) begin
                  state_reg <= SEL;
               end
            end

            SEL: begin
               if (fault_pend) begin
                  tx_data_reg  <= st_frame(HDR_FAULT, st_byte);
                  tx_start_reg <= 1'b1;
                  state_reg    <= LAUNCH;
               end else if (sts_pend_reg) begin
                  tx_data_reg  <= st_frame(HDR_STATUS, st_byte);
                  sts_pend_reg <= 1'b0;
                  tx_start_reg <= 1'b1;
                  state_reg    <= LAUNCH;
               end else if (vdc_pend_reg) begin
                  tx_data_reg  <= {HDR_VDC, vdc_snap_reg};
                  vdc_pend_reg <= 1'b0;
                  tx_start_reg <= 1'b1;
                  state_reg    <= LAUNCH;
`ifdef UP_TEMP_FRAME_EN
               end else if (tmp_pend_reg) begin
                  tx_data_reg  <= {HDR_TEMP, temp_snap_reg};
                  tmp_pend_reg <= 1'b0;
                  tx_start_reg <= 1'b1;
                  state_reg    <= LAUNCH;
`endif
               end else begin
                  state_reg <= IDLE;
               end
            end

            LAUNCH: begin
               cnt_reg   <= 13'd0;
               state_reg <= WAIT_ACK;
            end

            WAIT_ACK: begin
               if (tx_busy) begin
                  cnt_reg   <= 13'd0;
                  state_reg <= WAIT_DONE;
               end else if (wait_expired) begin
                  tx_err_reg <= 1'b1;
                  cnt_reg    <= 13'd0;
                  state_reg  <= GAP;
               end else begin
                  cnt_reg <= cnt_reg + 13'd1;
               end
            end

            WAIT_DONE: begin
               if (!tx_busy) begin
                  cnt_reg   <= 13'd0;
                  state_reg <= GAP;
               end else if (wait_expired) begin
                  tx_err_reg <= 1'b1;
                  cnt_reg    <= 13'd0;
                  state_reg  <= GAP;
               end else begin
                  cnt_reg <= cnt_reg + 13'd1;
               end
            end

            GAP: begin
               if (gap_done) begin
                  state_reg <= SEL;
               end else begin
                  cnt_reg <= cnt_reg + 13'd1;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign tx_start = tx_start_reg;
   assign tx_data  = tx_data_reg;
   assign tx_err   = tx_err_reg;
   assign sync_ovr = sync_ovr_reg;

endmodule

// File: tb/tb_up_frame_tx.sv
// tb_up_frame_tx -- directed self-checking bench for up_frame_tx.
// Expected frame counts follow UP_TEMP_FRAME_EN when it is defined.
`timescale 1ns/1ps
module tb_up_frame_tx;

   localparam logic [12:0] TX_TIMEOUT = 13'd4000;
   localparam logic [7:0]  FRM_GAP    = 8'd16;
   localparam int          BUSY_CYC   = 200;
`ifdef UP_TEMP_FRAME_EN
   localparam int          NFRM       = 3;
`else
   localparam int          NFRM       = 2;
`endif

   logic        clk;
   logic        rst;
   logic        sync_tick;
   logic        fault;
   logic [3:0]  igbt_flt;
   logic        Lockn;
   logic        start;
   logic        bypass;
   logic [15:0] vdc_data;
   logic [15:0] temp_data;
   logic        tx_busy;
   logic        tx_start;
   logic [23:0] tx_data;
   logic        tx_err;
   logic        sync_ovr;

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          cyc          = 0;
   bit          ser_en       = 1'b1;

   logic [23:0] frm_q[$];
   int          start_q[$];
   int          fall_q[$];

   up_frame_tx #(
      .TX_TIMEOUT (TX_TIMEOUT),
      .FRM_GAP    (FRM_GAP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sync_tick (sync_tick),
      .fault     (fault),
      .igbt_flt  (igbt_flt),
      .Lockn     (Lockn),
      .start     (start),
      .bypass    (bypass),
      .vdc_data  (vdc_data),
      .temp_data (temp_data),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_err    (tx_err),
      .sync_ovr  (sync_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Frame monitor: one entry (and one printed line) per cycle tx_start is high.
   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         frm_q.push_back(tx_data);
         start_q.push_back(cyc);
         $display("[TB] frame %h launched at cycle %0d", tx_data, cyc);
      end
   end

   // Serializer model: busy rises one cycle after the launch and stays high
   // for BUSY_CYC cycles; records the cycle busy fell.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (ser_en && tx_start === 1'b1) begin
            @(negedge clk);
            tx_busy = 1'b1;
            repeat (BUSY_CYC) @(negedge clk);
            tx_busy = 1'b0;
            fall_q.push_back(cyc);
         end
      end
   end

   task automatic clear_q();
      frm_q.delete();
      start_q.delete();
      fall_q.delete();
   endtask

   task automatic idle_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_frames(input int n, input int budget);
      for (int i = 0; i < budget && frm_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic pulse_tick(output int t);
      @(negedge clk);
      sync_tick = 1'b1;
      t = cyc;
      @(negedge clk);
      sync_tick = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      igbt_flt = 4'b0001;
      repeat (3) @(negedge clk);
      tests_run++;
      if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
      tests_run++;
      if (tx_data !== 24'h0) begin tests_failed++; $display("FAIL reset_tx_data: got %h want 000000", tx_data); end
      tests_run++;
      if (tx_err !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_err: got %b want 0", tx_err); end
      tests_run++;
      if (sync_ovr !== 1'b0) begin tests_failed++; $display("FAIL reset_sync_ovr: got %b want 0", sync_ovr); end
      rst = 1'b0;
      idle_wait(30);
      tests_run++;
      if (frm_q.size() !== 0) begin tests_failed++; $display("FAIL reset_no_fault_frame: got %0d frames want 0", frm_q.size()); end
      igbt_flt = 4'b0000;
      idle_wait(5);
   endtask

   task automatic test_report();
      int t0;
      logic [23:0] exp_f [3];
      clear_q();
      exp_f[0] = 24'hB101FE;
      exp_f[1] = 24'hB21234;
      exp_f[2] = 24'hB30056;
      fault = 1'b0; igbt_flt = 4'b0000; bypass = 1'b0; start = 1'b0; Lockn = 1'b1;
      vdc_data = 16'h1234; temp_data = 16'h0056;
      pulse_tick(t0);
      vdc_data = 16'hFFFF;
      temp_data = 16'hEEEE;
      wait_frames(NFRM, 2000);
      idle_wait(300);
      tests_run++;
      if (frm_q.size() !== NFRM) begin tests_failed++; $display("FAIL report_count: got %0d want %0d", frm_q.size(), NFRM); end
      for (int i = 0; i < NFRM && i < frm_q.size(); i++) begin
         tests_run++;
         if (frm_q[i] !== exp_f[i]) begin tests_failed++; $display("FAIL report_frame%0d: got %h want %h", i, frm_q[i], exp_f[i]); end
      end
      if (start_q.size() > 0) begin
         tests_run++;
         if (start_q[0] - t0 !== 2) begin tests_failed++; $display("FAIL report_latency: got %0d want 2", start_q[0] - t0); end
      end
      // busy drop seen in WAIT_DONE (1) + FRM_GAP in GAP + 1 in SEL
      for (int i = 1; i < NFRM && i < start_q.size() && i <= fall_q.size(); i++) begin
         tests_run++;
         if (start_q[i] - fall_q[i-1] !== int'(FRM_GAP) + 2) begin
            tests_failed++;
            $display("FAIL report_gap%0d: got %0d want %0d", i, start_q[i] - fall_q[i-1], int'(FRM_GAP) + 2);
         end
      end
      tests_run++;
      if (sync_ovr !== 1'b0) begin tests_failed++; $display("FAIL report_no_ovr: got %b want 0", sync_ovr); end
   endtask

   task automatic test_fault_latency();
      int t0;
      clear_q();
      fault = 1'b0; bypass = 1'b0; start = 1'b1; Lockn = 1'b1; igbt_flt = 4'b0000;
      idle_wait(5);
      @(negedge clk);
      igbt_flt = 4'b0100;
      t0 = cyc;
      wait_frames(1, 20);
      idle_wait(300);
      tests_run++;
      if (frm_q.size() !== 1) begin tests_failed++; $display("FAIL fault_count: got %0d want 1", frm_q.size()); end
      if (frm_q.size() > 0) begin
         tests_run++;
         if (frm_q[0] !== 24'hBF23DC) begin tests_failed++; $display("FAIL fault_frame: got %h want BF23DC", frm_q[0]); end
         tests_run++;
         if (start_q[0] - t0 !== 3) begin tests_failed++; $display("FAIL fault_latency: got %0d want 3", start_q[0] - t0); end
      end
   endtask

   task automatic test_fault_priority();
      int t0;
      logic [23:0] exp_f [4];
      clear_q();
      // igbt_flt stays 4'b0100, start=1, Lockn=1 -> status byte 8'h23
      vdc_data = 16'hABCD; temp_data = 16'h0077;
      exp_f[0] = 24'hB123DC;
      exp_f[1] = 24'hB2ABCD;
      exp_f[2] = 24'hBFB34C;
      exp_f[3] = 24'hB30077;
      pulse_tick(t0);
      wait_frames(2, 2000);
      idle_wait(20);
      igbt_flt = 4'b0110;
      idle_wait(20);
      fault = 1'b1;
      wait_frames(NFRM + 1, 3000);
      idle_wait(400);
      tests_run++;
      if (frm_q.size() !== NFRM + 1) begin tests_failed++; $display("FAIL prio_count: got %0d want %0d", frm_q.size(), NFRM + 1); end
      for (int i = 0; i < NFRM + 1 && i < frm_q.size(); i++) begin
         tests_run++;
         if (frm_q[i] !== exp_f[i]) begin tests_failed++; $display("FAIL prio_frame%0d: got %h want %h", i, frm_q[i], exp_f[i]); end
      end
      fault = 1'b0;
      igbt_flt = 4'b0000;
      idle_wait(20);
   endtask

   task automatic test_timeout();
      int t0;
      int l0;
      clear_q();
      ser_en = 1'b0;
      start = 1'b0; Lockn = 1'b1; vdc_data = 16'h0042;
      pulse_tick(t0);
      wait_frames(1, 20);
      l0 = (start_q.size() > 0) ? start_q[0] : cyc;
      for (int i = 0; i < 9000 && cyc < l0 + int'(TX_TIMEOUT); i++) @(negedge clk);
      tests_run++;
      if (tx_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_early: got tx_err %b want 0", tx_err); end
      @(negedge clk);
      tests_run++;
      if (tx_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_set: got tx_err %b want 1", tx_err); end
      wait_frames(2, 500);
      tests_run++;
      if (frm_q.size() < 2) begin
         tests_failed++;
         $display("FAIL timeout_next_frame: got %0d frames want 2", frm_q.size());
      end else begin
         tests_run++;
         if (frm_q[1] !== 24'hB20042) begin tests_failed++; $display("FAIL timeout_next_data: got %h want B20042", frm_q[1]); end
         tests_run++;
         if (start_q[1] - l0 !== int'(TX_TIMEOUT) + int'(FRM_GAP) + 2) begin
            tests_failed++;
            $display("FAIL timeout_next_time: got %0d want %0d", start_q[1] - l0, int'(TX_TIMEOUT) + int'(FRM_GAP) + 2);
         end
      end
      wait_frames(NFRM, 2 * int'(TX_TIMEOUT) + 200);
      idle_wait(int'(TX_TIMEOUT) + 100);
      tests_run++;
      if (tx_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_sticky: got tx_err %b want 1", tx_err); end
      ser_en = 1'b1;
   endtask

   task automatic test_overrun();
      int t0;
      int t1;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (tx_err !== 1'b0) begin tests_failed++; $display("FAIL ovr_reset_err: got tx_err %b want 0", tx_err); end
      clear_q();
      vdc_data = 16'h5555;
      pulse_tick(t0);
      repeat (8) @(negedge clk);
      tests_run++;
      if (sync_ovr !== 1'b0) begin tests_failed++; $display("FAIL ovr_before: got %b want 0", sync_ovr); end
      pulse_tick(t1);
      tests_run++;
      if (sync_ovr !== 1'b1) begin tests_failed++; $display("FAIL ovr_set: got %b want 1 (ticks %0d apart)", sync_ovr, t1 - t0); end
      wait_frames(NFRM, 2000);
      idle_wait(500);
      tests_run++;
      if (frm_q.size() !== NFRM) begin tests_failed++; $display("FAIL ovr_count: got %0d want %0d", frm_q.size(), NFRM); end
   endtask

   task automatic test_rst_abort();
      int t0;
      clear_q();
      vdc_data = 16'h0999;
      pulse_tick(t0);
      for (int i = 0; i < 100 && tx_busy !== 1'b1; i++) @(negedge clk);
      tests_run++;
      if (tx_busy !== 1'b1) begin tests_failed++; $display("FAIL abort_launch: got busy %b want 1", tx_busy); end
      idle_wait(20);
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL abort_tx_start: got %b want 0", tx_start); end
      tests_run++;
      if (tx_data !== 24'h0) begin tests_failed++; $display("FAIL abort_tx_data: got %h want 000000", tx_data); end
      rst = 1'b0;
      idle_wait(600);
      tests_run++;
      if (frm_q.size() !== 1) begin tests_failed++; $display("FAIL abort_no_more: got %0d frames want 1", frm_q.size()); end
      clear_q();
      pulse_tick(t0);
      wait_frames(1, 20);
      tests_run++;
      if (frm_q.size() < 1) begin
         tests_failed++;
         $display("FAIL abort_restart: got %0d frames want 1", frm_q.size());
      end else begin
         tests_run++;
         if (start_q[0] - t0 !== 2) begin tests_failed++; $display("FAIL abort_idle_latency: got %0d want 2", start_q[0] - t0); end
      end
      idle_wait(800);
   endtask

   initial begin
      rst = 1'b1;
      sync_tick = 1'b0;
      fault = 1'b0;
      igbt_flt = 4'b0000;
      Lockn = 1'b1;
      start = 1'b0;
      bypass = 1'b0;
      vdc_data = 16'h0;
      temp_data = 16'h0;
      test_reset();
      test_report();
      test_fault_latency();
      test_fault_priority();
      test_timeout();
      test_overrun();
      test_rst_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/up_frame_tx.md
UP_FRAME_TX -- requirements
Module: up_frame_tx

Interface
REQ-001 SHALL have parameter TX_TIMEOUT, default 13'd4000, meaning the maximum number of clk cycles spent waiting in one handshake phase.
REQ-002 SHALL have parameter FRM_GAP, default 8'd16, meaning the number of idle clk cycles between the end of one frame and the next tx_start.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 sync_tick  in  1  one-cycle pulse that starts a periodic report cycle.
REQ-006 fault  in  1  unit fault level.
REQ-007 igbt_flt  in  4  per-IGBT fault levels, one bit per IGBT.
REQ-008 Lockn, start, bypass  in  1 each  unit state levels.
REQ-009 vdc_data  in  16  DC-link voltage sample.
REQ-010 temp_data  in  16  heatsink temperature sample.
REQ-011 tx_busy  in  1  serializer busy flag.
REQ-012 tx_start  out  1  one-cycle frame launch pulse.
REQ-013 tx_data  out  24  frame word; valid and held while tx_start is high and until the frame completes.
REQ-014 tx_err  out  1  sticky handshake-timeout flag.
REQ-015 sync_ovr  out  1  sticky overrun flag: a sync_tick arrived while a report cycle was still in progress.

Function
REQ-016 Status byte ST SHALL be {fault, igbt_flt[3:0], bypass, start, Lockn}, sampled in the cycle the frame is loaded.
REQ-017 Frame formats:
- Status frame: {8'hB1, ST, ~ST}.
- Voltage frame: {8'hB2, vdc_snap}.
- Temperature frame: {8'hB3, temp_snap}.
- Fault frame: {8'hBF, ST, ~ST}.
REQ-018 On a sync_tick accepted in IDLE, the block SHALL:
- snapshot vdc_data and temp_data;
- queue the status, voltage and temperature frames, in that order.
REQ-019 If sync_tick arrives while a report cycle is not complete, it SHALL be ignored and sync_ovr SHALL be set.
REQ-020 A rising edge of fault or of any igbt_flt bit SHALL set fault_pend; fault_pend has priority over every queued frame at the next frame selection.
REQ-021 A new edge while fault_pend is already set SHALL NOT queue a second fault frame.
REQ-022 FSM states: IDLE, SEL, LAUNCH, WAIT_ACK, WAIT_DONE, GAP.
- IDLE to SEL: fault_pend is set or a sync_tick is accepted.
- SEL: load tx_data from the highest-priority pending frame, or return to IDLE if nothing is pending.
- LAUNCH: assert tx_start for exactly one cycle.
- WAIT_ACK: wait for tx_busy=1.
- WAIT_DONE: wait for tx_busy=0.
- GAP: count FRM_GAP cycles, then go to SEL.
REQ-023 Latency from a fault edge in IDLE to tx_start SHALL be 3 cycles: edge detect, SEL, LAUNCH.
REQ-024 A frame's pending bit SHALL clear on entry to LAUNCH; frames are never retransmitted.
REQ-025 A timeout counter SHALL reset on entry to each wait state.
REQ-026 When the timeout counter reaches TX_TIMEOUT, the block SHALL:
- set tx_err;
- drop the current frame;
- go to GAP.
REQ-027 tx_data SHALL hold its value from SEL until the next SEL.

Reset
REQ-028 When rst is high, the block SHALL:
- enter IDLE;
- force tx_start=0, tx_data=24'h0, tx_err=0, sync_ovr=0;
- clear all pending bits and counters;
- load the edge-detect history with the current fault inputs, so no fault frame follows reset release.
REQ-029 rst mid-frame SHALL abort the frame at once.

Configuration
REQ-030 With UP_TEMP_FRAME_EN defined, the temperature frame SHALL be queued on each accepted sync_tick.
REQ-031 Without UP_TEMP_FRAME_EN, no temperature frame is generated, temp_data is unused, and a report cycle contains two frames.

Structure
REQ-032 Frame header constants (8'hB1, 8'hB2, 8'hB3, 8'hBF) and the FSM state encodings SHALL live in a shared package, up_frame_pkg.
REQ-033 One sub-module SHALL hold the fault edge detection and fault_pend logic: up_flt_edge.

Verification
REQ-034 Reset sync_tick: vdc=16'h1234, temp=16'h0056, ST=8'h01, a serializer model holds busy for 200 cycles per frame -> the bench SHALL observe, in order, tx_data 24'hB101FE, 24'hB21234, 24'hB30056, each frame FRM_GAP cycles after the previous one.
REQ-035 igbt_flt 4'b0000->4'b0100 while idle, with fault=0, bypass=0, start=1, Lockn=1 -> ST=8'h23; tx_start exactly 3 cycles after the edge with tx_data=24'hBF23DC.
REQ-036 A fault edge during the voltage frame of a cycle -> the fault frame is sent before the temperature frame.
REQ-037 tx_busy held at 0 -> tx_err=1 after TX_TIMEOUT cycles, and the next frame is still launched.
REQ-038 A second sync_tick 10 cycles after the first -> sync_ovr=1, and only 3 frames are sent.
REQ-039 rst pulsed while in WAIT_DONE -> tx_start stays 0, the FSM is in IDLE, and no frame follows until the next sync_tick.
